// File: rtl/mul_pkg.sv
// Shared constants and FSM state type for the 6x6 shift-and-add multiplier.
package mul_pkg;

  localparam int N        = 6;
  localparam int PW       = 12;
  localparam int MAX_ITER = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/adder12.sv
// 12-bit ripple-carry adder made of three chained 4-bit slices.
module adder12 (
  input  logic [11:0] a,
  input  logic [11:0] b,
  input  logic        c0,
  output logic [11:0] s,
  output logic        c12
);

  logic [3:0] carry;

  assign carry[0] = c0;

  for (genvar gi = 0; gi < 3; gi++) begin : g_slice
    adder4 u_adder4 (
      .a    (a[gi*4 +: 4]),
      .b    (b[gi*4 +: 4]),
      .cin  (carry[gi]),
      .s    (s[gi*4 +: 4]),
      .cout (carry[gi+1])
    );
  end

  assign c12 = carry[3];

endmodule

// File: rtl/adder4.sv
// 4-bit ripple-carry adder built from a chain of full-adder cells.
module adder4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] carry;

  assign carry[0] = cin;

  for (genvar gi = 0; gi < 4; gi++) begin : g_fa
    assign s[gi]        = a[gi] ^ b[gi] ^ carry[gi];
    assign carry[gi+1]  = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
  end

  assign cout = carry[4];

endmodule

// File: rtl/mul6_shift_add.sv
// Sequential unsigned 6x6 shift-and-add multiplier with valid/ready handshakes;
// terminates early once the remaining multiplier bits are all zero.
module mul6_shift_add
  import mul_pkg::*;
#(
  parameter  int N  = 6,
  localparam int PW = 2 * N
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  a,
  input  logic [N-1:0]  b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] product,
  output logic          busy
);

  // The datapath is a single fixed-width 12-bit adder, so the operand width is locked.
  if (PW != mul_pkg::PW) begin : g_bad_width
    $error("mul6_shift_add: 2*N must equal the 12-bit adder width");
  end

  state_e        state_q,   state_d;
  logic [PW-1:0] acc_q,     acc_d;
  logic [PW-1:0] mcand_q,   mcand_d;
  logic [N-1:0]  mplier_q,  mplier_d;
  logic [PW-1:0] product_q, product_d;

  logic [PW-1:0] addend;
  logic [PW-1:0] sum;
  logic          c12;

  assign addend = mplier_q[0] ? mcand_q : '0;

  adder12 u_adder12 (
    .a   (acc_q),
    .b   (addend),
    .c0  (1'b0),
    .s   (sum),
    .c12 (c12)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    product_d = product_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          acc_d    = '0;
          mcand_d  = {{(PW-N){1'b0}}, a};
          mplier_d = b;
          if (b == '0) begin
            state_d   = ST_DONE;
            product_d = '0;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        acc_d    = sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        // Stop as soon as no set multiplier bits remain above the current one.
        if ((mplier_q >> 1) == '0) begin
          state_d   = ST_DONE;
          product_d = sum;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      product_q <= product_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign product   = product_q;

  // 63*63 fits in 12 bits, so the adder carry-out can never fire.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == ST_RUN) |-> !c12);

endmodule

// File: tb/tb_mul6_shift_add.sv
// Directed and exhaustive checks for the 6x6 shift-and-add multiplier.
module tb_mul6_shift_add;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  a;
  logic [5:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] product;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;
  bit c12_seen = 1'b0;

  always #5 clk = ~clk;

  mul6_shift_add dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  always @(negedge clk) begin
    if (rst_n && dut.c12) c12_seen = 1'b1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  function automatic int exp_latency(input logic [5:0] bv);
    for (int i = 5; i >= 0; i--) if (bv[i]) return i + 2;
    return 1;
  endfunction

  // One full transaction: accept, wait for the result, optional backpressure, handoff.
  task automatic run_op(input logic [5:0] ta, input logic [5:0] tbv, input int stall,
                        input int exp_lat, input bit hold_busy, input string tag);
    int lat;
    int guard;
    logic [11:0] exp_p;
    exp_p = 12'(ta) * 12'(tbv);
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(posedge clk); #1; guard++;
    end
    a = ta; b = tbv; in_valid = 1'b1;
    @(posedge clk); #1;
    if (!hold_busy) in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      if (hold_busy) begin
        a = 6'($urandom); b = 6'($urandom);
      end
      @(posedge clk); #1; lat++;
    end
    in_valid = 1'b0;
    check_eq({tag, " latency"}, lat, exp_lat);
    check_eq({tag, " product"}, product, exp_p);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check_eq({tag, " stall out_valid"}, out_valid, 1);
      check_eq({tag, " stall product"}, product, exp_p);
      check_eq({tag, " stall in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq({tag, " post in_ready"}, in_ready, 1);
    check_eq({tag, " post out_valid"}, out_valid, 0);
    check_eq({tag, " post product hold"}, product, exp_p);
    $display("txn %s a=%0d b=%0d product=%0d latency=%0d", tag, ta, tbv, product, lat);
  endtask

  initial begin
    int stall;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset in_ready", in_ready, 1);
    check_eq("reset out_valid", out_valid, 0);
    check_eq("reset busy", busy, 0);
    check_eq("reset product", product, 0);
    rst_n = 1'b1;

    // Reset during the third RUN cycle of 63*63.
    a = 6'd63; b = 6'd63; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check_eq("midrun busy", busy, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_eq("midrun rst in_ready", in_ready, 1);
    check_eq("midrun rst out_valid", out_valid, 0);
    check_eq("midrun rst product", product, 0);
    $display("txn midrun_reset in_ready=%0d out_valid=%0d product=%0d", in_ready, out_valid, product);
    run_op(6'd5, 6'd7, 0, 4, 1'b0, "after_reset");

    run_op(6'd63, 6'd63, 0, 7, 1'b0, "max");
    check_eq("c12 never set", c12_seen, 0);
    run_op(6'd45, 6'd0, 0, 1, 1'b0, "b_zero");
    run_op(6'd45, 6'd1, 0, 2, 1'b0, "b_one");
    run_op(6'd0, 6'd32, 0, 7, 1'b0, "a_zero_b32");
    run_op(6'd12, 6'd10, 5, 5, 1'b0, "backpressure");
    run_op(6'd9, 6'd11, 0, 5, 1'b1, "held_input");
    run_op(6'd33, 6'd0, 0, 1, 1'b1, "held_input_b0");

    for (int ia = 0; ia < 64; ia++) begin
      for (int ib = 0; ib < 64; ib++) begin
        stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
        run_op(6'(ia), 6'(ib), stall, exp_latency(6'(ib)), 1'b0,
               $sformatf("exh a=%0d b=%0d", ia, ib));
      end
    end
    check_eq("c12 never set final", c12_seen, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mul6_shift_add.md
Name: mul6_shift_add

Overview:
- Sequential unsigned 6x6 shift-and-add multiplier producing a 12-bit product.
- Uses one instance of the existing 12-bit ripple adder (adder12 over adder4) as its only arithmetic datapath.
- Each iteration feeds the adder the running accumulator and the shifted multiplicand, then registers the sum.
- Valid/ready handshake on input and output; sits between operand sourcing logic and any 12-bit result consumer.

Parameters:
- N, 6, operand width. Fixed: 2*N must equal the adder width of 12; any other value is a synthesis-time error.
- PW, 12, product width, equal to 2*N. Not overridable.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- in_valid  in  1  operands a and b are valid.
- in_ready  out  1  block can accept operands; high only in IDLE.
- a  in  6  multiplicand, unsigned.
- b  in  6  multiplier, unsigned.
- out_valid  out  1  product valid; high only in DONE.
- out_ready  in  1  consumer accepts the product.
- product  out  12  a*b, registered.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset: rst_n low at a rising edge forces state IDLE, acc=0, mcand=0, mplier=0 and product=0. in_ready reads 1; out_valid and busy read 0.
- Reset mid-operation discards the in-flight multiply; no partial result is ever presented.
- States: IDLE, RUN, DONE (encoding in the package).
- IDLE:
  - in_ready=1.
  - Accept when in_valid && in_ready.
  - On accept: acc<=0, mcand<={6'b0,a}, mplier<=b.
  - Next state is DONE if b==0, else RUN.
  - in_valid low: stay IDLE, registers hold.
- RUN, one iteration per cycle:
  - adder12 inputs: A=acc, B = mplier[0] ? mcand : 0, c0=0.
  - acc<=S.
  - mcand<=mcand<<1, with the bit shifted out of the top dropped.
  - mplier<=mplier>>1.
  - Next state is DONE when (mplier>>1)==0, which is early termination at the highest set bit of b; otherwise stay RUN.
- RUN cycle count:
  - k = floor(log2 b)+1 for b>0, in the range 1..6; k=0 for b==0.
  - At most 6 RUN cycles; no separate iteration counter is needed, but a 3-bit counter with assertion k<=6 is permitted.
- Overflow: c12 from the adder must always be 0, since max 63*63=3969 < 4096. c12 is left unconnected in function but asserted 0 in verification.
- DONE:
  - out_valid=1 and product=acc, held stable while out_ready is low.
  - On out_valid && out_ready, next state is IDLE.
  - in_ready=0 in DONE, so a new operand cannot be accepted in the same cycle as output handoff. Minimum spacing between accepts is k+2 cycles.
- Latency: out_valid first goes high k+1 cycles after the accept cycle.
  - b=0: 1 cycle.
  - b=63: 7 cycles.
- Operand changes on a and b after accept have no effect; operands are captured on accept.
- in_valid while busy is ignored, not queued. The upstream block must hold in_valid until in_ready.
- product updates only on the transition into DONE and holds its value in IDLE until the next result.

Decomposition:
- Shared package mul_pkg holds:
  - localparams N=6 and PW=12;
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - the max-iteration constant 6.
- Sub-module: reuse the existing adder12 unchanged as the sole datapath instance; no new sub-module.
- FSM, shift registers and handshake logic live in mul6_shift_add.

Test Plan:
- Reset mid-RUN:
  - Stimulus: a=63, b=63 accepted, rst_n low on the 3rd RUN cycle.
  - Required: next cycle in_ready=1, out_valid=0, product=0. A following a=5, b=7 returns 35 (0x023).
- Max operands:
  - Stimulus: a=63, b=63, out_ready=1.
  - Required: product=3969 (0xF81), out_valid 7 cycles after accept, c12 never 1.
- Zero and early termination:
  - Stimulus 1: a=45, b=0. Required: product=0 one cycle after accept.
  - Stimulus 2: a=45, b=1. Required: product=45 two cycles after accept.
  - Stimulus 3: a=0, b=32. Required: product=0 seven cycles after accept.
- Output backpressure:
  - Stimulus: a=12, b=10, out_ready low for 5 cycles.
  - Required: out_valid stays 1, product stays 120 (0x078), in_ready stays 0. On the out_ready handshake, in_ready=1 next cycle.
- Input held during busy:
  - Stimulus: in_valid held high with changing a and b during RUN.
  - Required: those operands are ignored; the first result matches the operands captured at accept.
- Exhaustive:
  - Stimulus: all 4096 (a,b) pairs with random out_ready stalls.
  - Required: product==a*b, latency==k+1 when no stall, no lost or duplicated results.
